// File: rtl/dso_pkg.sv
// Shared definitions for the scope command path: slave select codes,
// SPI master state encoding and the select decoder.
package dso_pkg;

  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;
  localparam logic [2:0] SS_TRIG = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    SHIFT,
    BACK
  } spi_state_t;

  // Active-low select bundle, one bit per slave.
  typedef struct packed {
    logic trig;
    logic ch1;
    logic ch2;
    logic ch3;
    logic eep;
  } ss_n_t;

  function automatic ss_n_t ss_decode(input logic [2:0] code);
    ss_n_t n;
    n = '1;
    case (code)
      SS_CH1:  n.ch1  = 1'b0;
      SS_CH2:  n.ch2  = 1'b0;
      SS_CH3:  n.ch3  = 1'b0;
      SS_EEP:  n.eep  = 1'b0;
      SS_TRIG: n.trig = 1'b0;
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_mstr_if.sv
// Dispatcher-side handshake plus the SPI bus pins of the SPI master.
interface spi_mstr_if;

  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        MISO;
  logic        SCLK;
  logic        MOSI;
  logic        trig_ss_n;
  logic        ch1_ss_n;
  logic        ch2_ss_n;
  logic        ch3_ss_n;
  logic        EEP_ss_n;
  logic        SPI_done;
  logic [15:0] SPI_rd_data;

  modport master (
    input  wrt_SPI, SPI_data, ss, MISO,
    output SCLK, MOSI, trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n,
           SPI_done, SPI_rd_data
  );

  modport slave (
    output wrt_SPI, SPI_data, ss, MISO,
    input  SCLK, MOSI, trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n,
           SPI_done, SPI_rd_data
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: counts SCLK_HALF clks per half period, toggles SCLK at each
// half-period end unless held high, and flags the clk on which SCLK flips.
module spi_sclk_gen #(
  parameter int unsigned SCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic half_end
);

  localparam int unsigned CNT_W = $clog2(SCLK_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             toggle;

  always_comb begin
    half_end = en && (cnt_q == CNT_W'(SCLK_HALF - 1));
    toggle   = half_end && !hold;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (en) begin
      cnt_d = half_end ? '0 : cnt_q + 1'b1;
      if (toggle) sclk_d = ~sclk_q;
    end
  end

  // Strobes are high in the cycle before the edge at which SCLK flips.
  assign sclk_rise = toggle && !sclk_q;
  assign sclk_fall = toggle && sclk_q;
  assign sclk      = sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_mstr.sv
// 16-bit full-duplex SPI master (CPOL=1, CPHA=1) driving the trigger DAC,
// three gain pots and the EEPROM; returns the received word with SPI_done.
module spi_mstr
  import dso_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 16
) (
  input  logic          clk,
  input  logic          rst,
  spi_mstr_if.master    bus
);

  spi_state_t  state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  ss_lat_q, ss_lat_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        smpl_q, smpl_d;
  logic        run_q, run_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [15:0] rd_data_q, rd_data_d;
  ss_n_t       ss_n_q, ss_n_d;

  logic gen_clr, gen_hold;
  logic sclk, sclk_rise, sclk_fall, half_end;

  spi_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (run_q),
    .clr       (gen_clr),
    .hold      (gen_hold),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .half_end  (half_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    ss_lat_d  = ss_lat_q;
    bit_cnt_d = bit_cnt_q;
    smpl_d    = smpl_q;
    rd_data_d = rd_data_q;
    ss_n_d    = ss_n_q;
    done_d    = 1'b0;
    // Counter starts one clk after the start edge, giving the 1+34*SCLK_HALF latency.
    run_d     = (state_q != IDLE);
    gen_clr   = (state_q == IDLE);
    // After the 16th rise SCLK stays high through the last high half and BACK.
    gen_hold  = (state_q == BACK) || (bit_cnt_q == 5'd16);

    case (state_q)
      IDLE: begin
        if (bus.wrt_SPI) begin
          shift_d   = bus.SPI_data;
          ss_lat_d  = bus.ss;
          bit_cnt_d = '0;
          smpl_d    = 1'b0;
          ss_n_d    = ss_decode(bus.ss);
          state_d   = FRONT;
        end
      end
      FRONT: begin
        ss_n_d = ss_decode(ss_lat_q);
        // The first fall only starts the data phase; MOSI already holds bit 15.
        if (half_end) state_d = SHIFT;
      end
      SHIFT: begin
        ss_n_d = ss_decode(ss_lat_q);
        if (sclk_rise) begin
          smpl_d    = bus.MISO;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (sclk_fall) shift_d = {shift_q[14:0], smpl_q};
        if (half_end && (bit_cnt_q == 5'd16)) state_d = BACK;
      end
      BACK: begin
        ss_n_d = ss_decode(ss_lat_q);
        if (half_end) begin
          shift_d   = {shift_q[14:0], smpl_q};
          rd_data_d = {shift_q[14:0], smpl_q};
          done_d    = 1'b1;
          ss_n_d    = '1;
          run_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mosi_d = shift_d[15];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      ss_lat_q  <= '0;
      bit_cnt_q <= '0;
      smpl_q    <= 1'b0;
      run_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      ss_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      ss_lat_q  <= ss_lat_d;
      bit_cnt_q <= bit_cnt_d;
      smpl_q    <= smpl_d;
      run_q     <= run_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
    end
  end

  assign bus.SCLK        = sclk;
  assign bus.MOSI        = mosi_q;
  assign bus.trig_ss_n   = ss_n_q.trig;
  assign bus.ch1_ss_n    = ss_n_q.ch1;
  assign bus.ch2_ss_n    = ss_n_q.ch2;
  assign bus.ch3_ss_n    = ss_n_q.ch3;
  assign bus.EEP_ss_n    = ss_n_q.eep;
  assign bus.SPI_done    = done_q;
  assign bus.SPI_rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_mstr.sv
// Self-checking bench for spi_mstr: directed frames plus random frames,
// checked against a frame-level model of select, bit order, latency and readback.
module tb_spi_mstr;
  import dso_pkg::*;

  localparam int unsigned SCLK_HALF = 16;
  localparam int unsigned LAT       = 1 + 34 * SCLK_HALF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mstr_if bus ();

  spi_mstr #(.SCLK_HALF(SCLK_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned frames_exp = 0;
  int unsigned start_cyc = 0;

  // Monitor / slave-model state
  bit          mon_on = 1'b0;
  logic        prev_sclk = 1'b1;
  int unsigned rise_tot = 0, fall_tot = 0, rise_base = 0, fall_base = 0;
  int unsigned done_seen = 0, sel_err = 0;
  int unsigned fr_start = 0, fr_end = 0;
  logic [2:0]  fr_code = 3'b000;
  logic [15:0] mosi_sh = '0;
  logic [15:0] slv_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected {trig,ch1,ch2,ch3,eep} active-low pattern for a slave code.
  function automatic logic [4:0] exp_sel(input logic [2:0] code);
    case (code)
      3'b111:  return 5'b01111;
      3'b001:  return 5'b10111;
      3'b010:  return 5'b11011;
      3'b011:  return 5'b11101;
      3'b100:  return 5'b11110;
      default: return 5'b11111;
    endcase
  endfunction

  function automatic logic [4:0] cur_sel();
    return {bus.trig_ss_n, bus.ch1_ss_n, bus.ch2_ss_n, bus.ch3_ss_n, bus.EEP_ss_n};
  endfunction

  always @(negedge clk) begin : monitor
    int unsigned idx;
    logic [4:0]  want;
    if (!mon_on) begin
      bus.MISO = 1'b0;
    end else begin
      if (bus.SCLK && !prev_sclk) begin
        rise_tot++;
        mosi_sh = {mosi_sh[14:0], bus.MOSI};
      end
      // Slave shifts its word out MSB-first on each SCLK fall.
      if (!bus.SCLK && prev_sclk) begin
        idx = fall_tot - fall_base;
        if (idx < 16) bus.MISO = slv_word[4'(15 - idx)];
        fall_tot++;
      end
      prev_sclk = bus.SCLK;
      if (bus.SPI_done) done_seen++;
      want = (cyc >= fr_start && cyc < fr_end) ? exp_sel(fr_code) : 5'b11111;
      if (cur_sel() !== want) sel_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Caller must be 2 time units after a posedge.
  task automatic start_frame(input logic [15:0] data, input logic [2:0] code,
                             input logic [15:0] slave);
    slv_word      = slave;
    fall_base     = fall_tot;
    rise_base     = rise_tot;
    bus.SPI_data  = data;
    bus.ss        = code;
    bus.wrt_SPI   = 1'b1;
    tick();
    bus.wrt_SPI   = 1'b0;
    start_cyc     = cyc;
    fr_start      = cyc;
    fr_end        = cyc + LAT;
    fr_code       = code;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] data, input logic [2:0] code,
                           input logic [15:0] slave, input bit inject);
    bit got;
    got = 1'b0;
    start_frame(data, code, slave);
    for (int i = 0; i < 700 && !got; i++) begin
      tick();
      if (bus.SPI_done) begin
        got = 1'b1;
      end else begin
        bus.SPI_data = 16'($urandom);
        bus.ss       = 3'($urandom);
        bus.wrt_SPI  = inject && (cyc - start_cyc == 199);
        if (bus.wrt_SPI) bus.ss = SS_CH1;
      end
    end
    bus.wrt_SPI = 1'b0;
    frames_exp++;
    check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_latency"}, cyc - start_cyc, LAT);
    check_eq({tag, "_rd_data"}, 32'(bus.SPI_rd_data), 32'(slave));
    check_eq({tag, "_sclk_rises"}, rise_tot - rise_base, 32'd16);
    check_eq({tag, "_sclk_falls"}, fall_tot - fall_base, 32'd16);
    check_eq({tag, "_mosi_bits"}, 32'(mosi_sh), 32'(data));
    check_eq({tag, "_select_errs"}, sel_err, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int unsigned base;
    logic [15:0] d, s;
    logic [2:0]  c;

    rst          = 1'b1;
    bus.wrt_SPI  = 1'b0;
    bus.SPI_data = '0;
    bus.ss       = '0;
    repeat (3) tick();
    check_eq("rst_sel", 32'(cur_sel()), 32'h1F);
    check_eq("rst_sclk", 32'(bus.SCLK), 32'd1);
    check_eq("rst_mosi", 32'(bus.MOSI), 32'd0);
    check_eq("rst_done", 32'(bus.SPI_done), 32'd0);
    check_eq("rst_rd_data", 32'(bus.SPI_rd_data), 32'd0);
    rst    = 1'b0;
    mon_on = 1'b1;
    repeat (4) tick();

    run_frame("trig", 16'h00EF, SS_TRIG, 16'($urandom), 1'b0);
    repeat (5) tick();

    run_frame("loopback", 16'h5CEF, SS_EEP, 16'hA5C3, 1'b0);
    repeat (5) tick();

    base = done_seen;
    run_frame("pots", 16'h13DD, SS_CH2, 16'h3C96, 1'b1);
    repeat (600) tick();
    check_eq("pots_single_done", done_seen - base, 32'd1);
    check_eq("pots_rd_hold", 32'(bus.SPI_rd_data), 32'h3C96);

    run_frame("unused", 16'($urandom), 3'b000, 16'($urandom), 1'b0);
    repeat (5) tick();

    run_frame("b2b_a", 16'hC35A, SS_CH3, 16'h1234, 1'b0);
    check_eq("b2b_released", 32'(cur_sel()), 32'h1F);
    run_frame("b2b_b", 16'h0FF1, SS_CH3, 16'hFEDC, 1'b0);
    repeat (5) tick();

    // Abort mid-SHIFT with reset: selects drop, no completion, then recover.
    base = done_seen;
    start_frame(16'hBEEF, SS_CH1, 16'h7777);
    repeat (300) tick();
    rst    = 1'b1;
    fr_end = cyc + 1;
    tick();
    rst = 1'b0;
    check_eq("abort_sel", 32'(cur_sel()), 32'h1F);
    check_eq("abort_sclk", 32'(bus.SCLK), 32'd1);
    check_eq("abort_mosi", 32'(bus.MOSI), 32'd0);
    check_eq("abort_rd_data", 32'(bus.SPI_rd_data), 32'd0);
    repeat (600) tick();
    check_eq("abort_no_done", done_seen - base, 32'd0);
    run_frame("after_abort", 16'h8001, SS_CH1, 16'h4E21, 1'b0);
    repeat (3) tick();

    for (int k = 0; k < 5; k++) begin
      d = 16'($urandom);
      s = 16'($urandom);
      c = 3'($urandom);
      run_frame($sformatf("rand%0d", k), d, c, s, 1'b0);
      repeat ($urandom_range(0, 4)) tick();
    end

    repeat (4) tick();
    check_eq("done_total", done_seen, frames_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
